// File: rtl/mips_perf_monitor.sv
// Run-control and performance monitor for the pipelined MIPS core: IDLE/RUN/DONE
// control, saturating event counters and a branch trace FIFO with valid/ready drain.
module mips_perf_monitor #(
   parameter int PC_W        = 10,
   parameter int CNT_W       = 16,
   parameter int TRACE_DEPTH = 8,
   parameter int CYCLE_LIMIT = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [PC_W-1:0]    PC_in,
   input  logic [31:0]        Instruction_in,
   input  logic               Branch_in,
   input  logic               Zero_in,
   input  logic               MemWrite_in,
   input  logic               RegWrite_in,
   input  logic               stall_in,
   output logic [1:0]         state_out,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   retire_cnt,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   taken_cnt,
   output logic [CNT_W-1:0]   store_cnt,
   output logic [CNT_W-1:0]   drop_cnt,
   output logic               overflow,
   output logic               trace_valid,
   output logic [PC_W+31:0]   trace_data,
   input  logic               trace_ready
);

   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int ENT_W = PC_W + 32;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(TRACE_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       cycle_r, retire_r, stall_r, taken_r, store_r, drop_r;
   logic                   overflow_r;
   logic [ENT_W-1:0]       mem_r [TRACE_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic [PTR_W:0]         count_r, count_s, after_pop_s;
   logic                   valid_r;
   logic [ENT_W-1:0]       head_r, head_s;

   logic                   count_en_s, retire_s, ev_stall_s, ev_retire_s, ev_taken_s, ev_store_s;
   logic                   pop_s, full_s, push_s, drop_s, limit_hit_s, sat_s, unused_s;
   logic [ENT_W-1:0]       push_data_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != CNT_MAX)) begin
         sat_inc = v + CNT_ONE;
      end else begin
         sat_inc = v;
      end
   endfunction

   // True when this event lands the counter on (or keeps it at) saturation.
   function automatic logic sat_hit(input logic [CNT_W-1:0] v, input logic en);
      sat_hit = en && (v >= (CNT_MAX - CNT_ONE));
   endfunction

   assign unused_s    = RegWrite_in;
   assign retire_s    = ~stall_in & (Instruction_in != 32'h0);
   assign count_en_s  = (state_r == ST_RUN) & ~start;
   assign ev_stall_s  = count_en_s & stall_in;
   assign ev_retire_s = count_en_s & retire_s;
   assign ev_taken_s  = ev_retire_s & Branch_in & Zero_in;
   assign ev_store_s  = ev_retire_s & MemWrite_in;
   assign limit_hit_s = (CYCLE_LIMIT != 0) && (cycle_r == LIMIT_M1);

   assign pop_s       = valid_r & trace_ready & ~start;
   assign full_s      = (count_r == DEPTH_C);
   assign push_s      = ev_taken_s & (~full_s | pop_s);
   assign drop_s      = ev_taken_s & full_s & ~pop_s;
   assign push_data_s = {PC_in, Instruction_in};

   assign sat_s = sat_hit(cycle_r, count_en_s) | sat_hit(retire_r, ev_retire_s) |
                  sat_hit(stall_r, ev_stall_s) | sat_hit(taken_r, ev_taken_s) |
                  sat_hit(store_r, ev_store_s) | sat_hit(drop_r, drop_s);

   // Next-state logic; start has priority over stop and the cycle limit.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_RUN;
            else       state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (start)                     state_s = ST_RUN;
            else if (stop || limit_hit_s)  state_s = ST_DONE;
            else                           state_s = ST_RUN;
         end
         ST_DONE: begin
            if (start) state_s = ST_RUN;
            else       state_s = ST_DONE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FIFO pointer/occupancy update and the registered head entry for the next cycle.
   always_comb begin
      rd_ptr_s    = pop_s  ? (rd_ptr_r + PTR_W'(1'b1)) : rd_ptr_r;
      wr_ptr_s    = push_s ? (wr_ptr_r + PTR_W'(1'b1)) : wr_ptr_r;
      after_pop_s = count_r - (PTR_W+1)'(pop_s);
      count_s     = after_pop_s + (PTR_W+1)'(push_s);
      if (count_s == '0) begin
         head_s = '0;
      end else if (push_s && (after_pop_s == '0)) begin
         head_s = push_data_s;
      end else begin
         head_s = mem_r[rd_ptr_s];
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Event counters and sticky overflow; start clears them on its own edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset || start) begin
         cycle_r    <= '0;
         retire_r   <= '0;
         stall_r    <= '0;
         taken_r    <= '0;
         store_r    <= '0;
         drop_r     <= '0;
         overflow_r <= 1'b0;
      end else begin
         cycle_r    <= sat_inc(cycle_r, count_en_s);
         retire_r   <= sat_inc(retire_r, ev_retire_s);
         stall_r    <= sat_inc(stall_r, ev_stall_s);
         taken_r    <= sat_inc(taken_r, ev_taken_s);
         store_r    <= sat_inc(store_r, ev_store_s);
         drop_r     <= sat_inc(drop_r, drop_s);
         overflow_r <= overflow_r | sat_s | drop_s;
      end
   end

   // Trace FIFO control registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset || start) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         valid_r  <= 1'b0;
         head_r   <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_s;
         rd_ptr_r <= rd_ptr_s;
         count_r  <= count_s;
         valid_r  <= (count_s != '0);
         head_r   <= head_s;
      end
   end

   // Trace storage; contents are only meaningful behind the occupancy count.
   always_ff @(posedge clock) begin
      if (push_s) mem_r[wr_ptr_r] <= push_data_s;
   end

   assign state_out   = state_r;
   assign cycle_cnt   = cycle_r;
   assign retire_cnt  = retire_r;
   assign stall_cnt   = stall_r;
   assign taken_cnt   = taken_r;
   assign store_cnt   = store_r;
   assign drop_cnt    = drop_r;
   assign overflow    = overflow_r;
   assign trace_valid = valid_r;
   assign trace_data  = head_r;

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Directed bench for mips_perf_monitor: default, CYCLE_LIMIT=4 and CNT_W=4 instances.
module tb_mips_perf_monitor;
   logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
   logic [9:0]  pc = 10'h0;
   logic [31:0] instr = 32'h0;
   logic br = 1'b0, zero = 1'b0, memw = 1'b0, regw = 1'b0, stall = 1'b0, ready = 1'b0;

   logic [1:0]  st_m, st_l, st_s;
   logic [15:0] cyc_m, ret_m, stl_m, tak_m, sto_m, drp_m;
   logic [15:0] cyc_l, ret_l, stl_l, tak_l, sto_l, drp_l;
   logic [3:0]  cyc_s, ret_s, stl_s, tak_s, sto_s, drp_s;
   logic        ovf_m, ovf_l, ovf_s, tv_m, tv_l, tv_s;
   logic [41:0] td_m, td_l, td_s;

   int n_tests = 0;
   int n_fail  = 0;

   mips_perf_monitor u_main (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .PC_in(pc),
      .Instruction_in(instr), .Branch_in(br), .Zero_in(zero), .MemWrite_in(memw),
      .RegWrite_in(regw), .stall_in(stall), .state_out(st_m), .cycle_cnt(cyc_m),
      .retire_cnt(ret_m), .stall_cnt(stl_m), .taken_cnt(tak_m), .store_cnt(sto_m),
      .drop_cnt(drp_m), .overflow(ovf_m), .trace_valid(tv_m), .trace_data(td_m),
      .trace_ready(ready));

   mips_perf_monitor #(.CYCLE_LIMIT(4)) u_lim (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .PC_in(pc),
      .Instruction_in(instr), .Branch_in(br), .Zero_in(zero), .MemWrite_in(memw),
      .RegWrite_in(regw), .stall_in(stall), .state_out(st_l), .cycle_cnt(cyc_l),
      .retire_cnt(ret_l), .stall_cnt(stl_l), .taken_cnt(tak_l), .store_cnt(sto_l),
      .drop_cnt(drp_l), .overflow(ovf_l), .trace_valid(tv_l), .trace_data(td_l),
      .trace_ready(ready));

   mips_perf_monitor #(.CNT_W(4)) u_small (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .PC_in(pc),
      .Instruction_in(instr), .Branch_in(br), .Zero_in(zero), .MemWrite_in(memw),
      .RegWrite_in(regw), .stall_in(stall), .state_out(st_s), .cycle_cnt(cyc_s),
      .retire_cnt(ret_s), .stall_cnt(stl_s), .taken_cnt(tak_s), .store_cnt(sto_s),
      .drop_cnt(drp_s), .overflow(ovf_s), .trace_valid(tv_s), .trace_data(td_s),
      .trace_ready(ready));

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [9:0]  epc;
      logic [31:0] ein;

      // Reset state
      #12;
      check_eq("rst_state", 64'(st_m), 64'd0);
      check_eq("rst_cycle", 64'(cyc_m), 64'd0);
      check_eq("rst_ovf", 64'(ovf_m), 64'd0);
      check_eq("rst_valid", 64'(tv_m), 64'd0);
      check_eq("rst_data", 64'(td_m), 64'd0);
      reset = 1'b0;
      tick();

      // 1: five retiring cycles, stop on the fifth
      start = 1'b1; tick(); start = 1'b0;
      check_eq("t1_run", 64'(st_m), 64'd1);
      instr = 32'h0002_0820;
      repeat (4) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      check_eq("t1_cycle", 64'(cyc_m), 64'd5);
      check_eq("t1_retire", 64'(ret_m), 64'd5);
      check_eq("t1_stall", 64'(stl_m), 64'd0);
      check_eq("t1_done", 64'(st_m), 64'd2);
      tick();
      check_eq("t1_frozen", 64'(cyc_m), 64'd5);

      // 2: restart from DONE, 3 stalls then 2 NOPs
      start = 1'b1; tick(); start = 1'b0;
      check_eq("t2_clear", 64'(cyc_m), 64'd0);
      stall = 1'b1; repeat (3) tick();
      stall = 1'b0; instr = 32'h0; repeat (2) tick();
      check_eq("t2_stall", 64'(stl_m), 64'd3);
      check_eq("t2_retire", 64'(ret_m), 64'd0);
      check_eq("t2_cycle", 64'(cyc_m), 64'd5);
      // stores: two retired, one stalled
      instr = 32'hAC43_0004; memw = 1'b1; repeat (2) tick();
      stall = 1'b1; tick(); stall = 1'b0; memw = 1'b0;
      check_eq("t2_store", 64'(sto_m), 64'd2);
      check_eq("t2_retire2", 64'(ret_m), 64'd2);

      // 3: single taken branch, held while not ready
      pc = 10'h010; instr = 32'h1022_0003; br = 1'b1; zero = 1'b1; tick();
      zero = 1'b0; instr = 32'h1022_0005;
      check_eq("t3_valid", 64'(tv_m), 64'd1);
      check_eq("t3_data", 64'(td_m), 64'({10'h010, 32'h1022_0003}));
      check_eq("t3_taken", 64'(tak_m), 64'd1);
      tick();
      br = 1'b0; instr = 32'h0;
      check_eq("t3_hold_v", 64'(tv_m), 64'd1);
      check_eq("t3_hold_d", 64'(td_m), 64'({10'h010, 32'h1022_0003}));
      check_eq("t3_not_taken", 64'(tak_m), 64'd1);
      ready = 1'b1; tick(); ready = 1'b0;
      check_eq("t3_drained", 64'(tv_m), 64'd0);

      // 4: ten taken branches into an 8-deep FIFO
      start = 1'b1; tick(); start = 1'b0;
      br = 1'b1; zero = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pc = 10'(i); instr = 32'h1000_0000 + 32'(i); tick();
      end
      check_eq("t4_taken", 64'(tak_m), 64'd10);
      check_eq("t4_drop", 64'(drp_m), 64'd2);
      check_eq("t4_ovf", 64'(ovf_m), 64'd1);
      check_eq("t4_head", 64'(td_m), 64'({10'd0, 32'h1000_0000}));
      pc = 10'd10; instr = 32'h1000_000A; ready = 1'b1; tick();
      br = 1'b0; zero = 1'b0; instr = 32'h0;
      check_eq("t4_drop_pp", 64'(drp_m), 64'd2);
      for (int k = 0; k < 8; k++) begin
         epc = (k < 7) ? 10'(k + 1) : 10'd10;
         ein = 32'h1000_0000 + 32'(epc);
         check_eq($sformatf("t4_pop%0d", k), 64'({tv_m, td_m}), 64'({1'b1, epc, ein}));
         tick();
      end
      ready = 1'b0;
      check_eq("t4_empty", 64'(tv_m), 64'd0);

      // start and stop together: start wins
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check_eq("ss_state", 64'(st_m), 64'd1);
      check_eq("ss_clear", 64'({ovf_m, cyc_m, drp_m}), 64'd0);

      // 5: CYCLE_LIMIT=4
      reset = 1'b1; tick(); reset = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      instr = 32'h0002_0820;
      repeat (4) tick();
      check_eq("t5_done", 64'(st_l), 64'd2);
      check_eq("t5_cycle", 64'(cyc_l), 64'd4);
      repeat (2) tick();
      check_eq("t5_frozen", 64'(cyc_l), 64'd4);
      start = 1'b1; tick(); start = 1'b0;
      check_eq("t5_restart", 64'({st_l, cyc_l}), 64'({2'b01, 16'd0}));

      // 6: CNT_W=4 saturation, then asynchronous reset mid-run
      reset = 1'b1; tick(); reset = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (20) tick();
      check_eq("t6_cycle", 64'(cyc_s), 64'd15);
      check_eq("t6_ovf", 64'(ovf_s), 64'd1);
      check_eq("t6_run", 64'(st_s), 64'd1);
      reset = 1'b1;
      #1;
      check_eq("t6_async", 64'({st_s, cyc_s, ret_s, ovf_s, tv_s}), 64'd0);
      check_eq("t6_async_m", 64'({st_m, cyc_m, tv_m, td_m}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
